// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / divide unit: one shift-add or restoring
// shift-subtract step per cycle, with sign handling around an unsigned core.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  count;
    logic        accept;
    logic        last_iter;

    // Operation context captured at acceptance.
    logic        is_div;
    logic        zero_div;
    logic        neg_res;
    logic        neg_rem;
    logic [31:0] opnd;
    logic [63:0] work;
    logic [63:0] work_next;

    // Operand decode, only meaningful in the acceptance cycle.
    logic        in_signed;
    logic        in_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;

    // Iteration and sign-correction datapath.
    logic [32:0] add_sum;
    logic [32:0] rem_shift;
    logic [32:0] sub_diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] dividend_fix;

    assign accept    = (state == IDLE) && start;
    assign last_iter = (count == 6'd31);

    always_comb begin
        in_signed = ~op[0];
        in_div    = op[1];
        a_neg     = in_signed & A[31];
        b_neg     = in_signed & B[31];
        a_abs     = a_neg ? 32'd0 - A : A;
        b_abs     = b_neg ? 32'd0 - B : B;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (zero_div || last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // work holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        add_sum   = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
        rem_shift = work[63:31];
        sub_diff  = rem_shift - {1'b0, opnd};
        if (!is_div)
            work_next = {add_sum, work[31:1]};
        else if (!sub_diff[32])
            work_next = {sub_diff[31:0], work[30:0], 1'b1};
        else
            work_next = {work[62:0], 1'b0};
    end

    always_comb begin
        prod_fix     = neg_res ? 64'd0 - work_next : work_next;
        quo_fix      = neg_res ? 32'd0 - work_next[31:0] : work_next[31:0];
        rem_fix      = neg_rem ? 32'd0 - work_next[63:32] : work_next[63:32];
        dividend_fix = neg_rem ? 32'd0 - work[31:0] : work[31:0];
    end

    // NOTE: pure datapath registers carry no reset; they are always loaded at acceptance before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div   <= in_div;
            zero_div <= in_div && (B == 32'd0);
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            opnd     <= in_div ? b_abs : a_abs;
            work     <= {32'd0, in_div ? a_abs : b_abs};
        end else if (state == CALC) begin
            work     <= work_next;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= 6'd0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept)
                count <= 6'd0;
            else if (state == CALC)
                count <= count + 6'd1;

            if (state == CALC) begin
                if (zero_div) begin
                    // Divide by zero returns the dividend untouched as the remainder.
                    hi          <= dividend_fix;
                    lo          <= 32'hFFFF_FFFF;
                    div_by_zero <= 1'b1;
                end else if (last_iter) begin
                    div_by_zero <= 1'b0;
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: table of operations with hand-computed
// results and latencies, plus sequences for restart-while-busy and reset abort.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[14];

    muldiv_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept an operation at the next edge, scramble A/B afterwards, then
    // watch busy/done cycle by cycle until the operation completes.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int done_at, output int busy_n, output int done_n);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = 32'hA5A5_5A5A;
        B = 32'h0000_0000;
        op = MULT;
        done_at = 0; busy_n = 0; done_n = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = k;
            end
            if (done_at != 0 && !busy) break;
        end
    endtask

    initial begin
        int done_at, busy_n, done_n;
        logic [31:0] hold_hi, hold_lo;

        vecs[0]  = '{"multu_max",    MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
        vecs[1]  = '{"mult_m3x7",    MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
        vecs[2]  = '{"div_m7d2",     DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[3]  = '{"divu_100d7",   DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33};
        vecs[4]  = '{"div_min_m1",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 33};
        vecs[5]  = '{"divu_by0",     DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, 2};
        vecs[6]  = '{"multu_2x3",    MULTU, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, 33};
        vecs[7]  = '{"mult_minsq",   MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, 33};
        vecs[8]  = '{"div_7dm2",     DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 33};
        vecs[9]  = '{"div_m7by0",    DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 2};
        vecs[10] = '{"divu_5d5",     DIVU,  32'd5,         32'd5,         32'd0,         32'd1,         1'b0, 33};
        vecs[11] = '{"mult_m1xm1",   MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0, 33};
        vecs[12] = '{"divu_max_d1",  DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, 33};
        vecs[13] = '{"divu_big_div", DIVU,  32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         1'b0, 33};

        reset = 1'b1; start = 1'b0; op = MULTU; A = 32'd0; B = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, done_at, busy_n, done_n);
            check({vecs[i].name, "_done_at"}, done_at, vecs[i].exp_lat);
            check({vecs[i].name, "_busy_n"},  busy_n,  vecs[i].exp_lat);
            check({vecs[i].name, "_done_n"},  done_n,  1);
            check({vecs[i].name, "_hilo"},    {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
            check({vecs[i].name, "_dbz"},     {63'd0, div_by_zero}, {63'd0, vecs[i].exp_dbz});
        end

        // Idle with start low: results must hold while inputs wander.
        hold_hi = hi; hold_lo = lo;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            op = 2'(k); A = 32'h1111_1111 * k; B = 32'd3 + k;
        end
        @(negedge clk);
        check("idle_hold_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'h0000_0000} & 64'd0 | {hold_hi, hold_lo});
        check("idle_hold_busy", {63'd0, busy}, 64'd0);

        // Start pulse with new operands in the middle of a DIVU is ignored.
        @(negedge clk);
        op = DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_at = 0; done_n = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 5) begin
                op = MULTU; A = 32'd9; B = 32'd9; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = k;
            end
        end
        check("restart_done_at", done_at, 33);
        check("restart_done_n",  done_n,  1);
        check("restart_hilo",    {hi, lo}, {32'd2, 32'd14});

        // Reset in the middle of a MULTU, with start held high alongside it.
        @(negedge clk);
        op = MULTU; A = 32'hFFFF_FFFF; B = 32'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        reset = 1'b0; start = 1'b0;
        done_n = 0; busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) done_n++;
            if (busy) busy_n++;
        end
        check("abort_no_done", done_n, 0);
        check("abort_no_busy", busy_n, 0);
        check("abort_hilo_hold", {hi, lo}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
